// File: rtl/i2c_master_byte.sv
// -----------------------------------------------------------------------------
// i2c_master_byte
//
// Single-byte I2C bus master. A host request (addr, rw, wdata) becomes one
// complete bus transaction:
//   START, addr+R/W, ACK check, one data byte, ACK/NACK, STOP.
// No clock stretching is supported: SCL is never read back.
//
// Every bit is split into four quarters Q0..Q3, each CLK_DIV clk cycles long.
// SCL is held low in Q0-Q1 and released in Q2-Q3. SDA changes at the start of
// Q0, and sda_in is sampled on the last clk of Q2.
//
// Parameters
//   CLK_DIV   clk cycles per SCL quarter-period (2..65535).
//             SCL frequency = clk / (4*CLK_DIV).
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     one-cycle request strobe, accepted only while idle
//   rw        0 = write wdata, 1 = read one byte
//   addr      7-bit target slave address
//   wdata     byte to write, sent MSB first
//   busy      high from the cycle after acceptance until done
//   done      one-cycle pulse at the end of every transaction
//   ack_err   address or write-data NACK; valid with done, held until the
//             next acceptance
//   rdata     byte read; valid with done on a read without ack_err
//   scl_low   1 = pull SCL low, 0 = release
//   sda_low   1 = pull SDA low, 0 = release
//   sda_in    sampled SDA pad level
// -----------------------------------------------------------------------------
module i2c_master_byte #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       scl_low,
  output logic       sda_low,
  input  logic       sda_in
);

  localparam int unsigned      DIV_W      = 16;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_AACK,
    S_WBYTE,
    S_WACK,
    S_RBYTE,
    S_RNACK,
    S_STOP
  } state_t;

  state_t           r_state,     w_state_nx;
  logic [DIV_W-1:0] r_div,       w_div_nx;
  logic [1:0]       r_quarter,   w_quarter_nx;
  logic [2:0]       r_bit,       w_bit_nx;
  logic [7:0]       r_rx,        w_rx_nx;
  logic             r_sample,    w_sample_nx;
  logic             r_ack_err,   w_ack_err_nx;
  logic [7:0]       r_rdata,     w_rdata_nx;
  logic             r_done,      w_done_nx;
  logic             r_scl_low;
  logic             r_sda_low;
  logic [6:0]       r_addr;
  logic             r_rw;
  logic [7:0]       r_wdata;

  logic             w_accept;
  logic [1:0]       w_lines_nx;

  // The done cycle is already idle, but a request in that cycle is still
  // ignored; the earliest acceptance is the cycle after done.
  assign w_accept = start && (r_state == S_IDLE) && !r_done;

  // Bus drive for a given position in the transaction: {scl_low, sda_low}.
  function automatic logic [1:0] drive_lines(
    input state_t     st,
    input logic [1:0] q,
    input logic [2:0] b,
    input logic [7:0] addr_byte,
    input logic [7:0] data_byte
  );
    logic scl_l;
    logic sda_l;
    scl_l = 1'b0;
    sda_l = 1'b0;
    case (st)
      S_IDLE:  ;
      // SCL stays released for the whole START bit; SDA falls at Q2.
      S_START: sda_l = q[1];
      S_ADDR: begin
        scl_l = ~q[1];
        sda_l = ~addr_byte[3'd7 - b];
      end
      S_WBYTE: begin
        scl_l = ~q[1];
        sda_l = ~data_byte[3'd7 - b];
      end
      // SDA held low until Q3 so it rises while SCL is high.
      S_STOP: begin
        scl_l = ~q[1];
        sda_l = (q != 2'd3);
      end
      // Acknowledge and read bits: SCL clocks, SDA released.
      default: scl_l = ~q[1];
    endcase
    return {scl_l, sda_l};
  endfunction

  // NOTE: every signal written here gets a default first, so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    w_state_nx   = r_state;
    w_div_nx     = r_div;
    w_quarter_nx = r_quarter;
    w_bit_nx     = r_bit;
    w_rx_nx      = r_rx;
    w_sample_nx  = r_sample;
    w_ack_err_nx = r_ack_err;
    w_rdata_nx   = r_rdata;
    w_done_nx    = 1'b0;

    if (r_state == S_IDLE) begin
      if (w_accept) begin
        w_state_nx   = S_START;
        w_div_nx     = DIV_RELOAD;
        w_quarter_nx = 2'd0;
        w_bit_nx     = 3'd0;
        w_ack_err_nx = 1'b0;
      end
    end else if (r_div != '0) begin
      w_div_nx = r_div - 16'd1;
    end else begin
      // Last clk of the current quarter.
      w_div_nx     = DIV_RELOAD;
      w_quarter_nx = r_quarter + 2'd1;

      if (r_quarter == 2'd2) begin
        w_sample_nx = sda_in;
        if (r_state == S_RBYTE) begin
          w_rx_nx = {r_rx[6:0], sda_in};
        end
      end

      if (r_quarter == 2'd3) begin
        // Byte states count 0..7 and wrap; single-bit states keep it at 0.
        if (r_state == S_ADDR || r_state == S_WBYTE || r_state == S_RBYTE) begin
          w_bit_nx = r_bit + 3'd1;
        end else begin
          w_bit_nx = 3'd0;
        end

        case (r_state)
          S_START: w_state_nx = S_ADDR;
          S_ADDR:  if (r_bit == 3'd7) w_state_nx = S_AACK;
          S_AACK: begin
            if (r_sample) begin
              w_ack_err_nx = 1'b1;
              w_state_nx   = S_STOP;
            end else begin
              w_state_nx   = r_rw ? S_RBYTE : S_WBYTE;
            end
          end
          S_WBYTE: if (r_bit == 3'd7) w_state_nx = S_WACK;
          S_WACK: begin
            if (r_sample) w_ack_err_nx = 1'b1;
            w_state_nx = S_STOP;
          end
          S_RBYTE: begin
            if (r_bit == 3'd7) begin
              w_rdata_nx = r_rx;
              w_state_nx = S_RNACK;
            end
          end
          S_RNACK: w_state_nx = S_STOP;
          S_STOP: begin
            w_done_nx  = 1'b1;
            w_state_nx = S_IDLE;
          end
          default: w_state_nx = S_IDLE;
        endcase
      end
    end
  end

  // The line drives are decoded from the next-state values and registered,
  // so SCL/SDA come straight from flops (no decode glitches on the pads)
  // while still changing in the same cycle as the state they belong to.
  assign w_lines_nx = drive_lines(w_state_nx, w_quarter_nx, w_bit_nx,
                                  {r_addr, r_rw}, r_wdata);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values present before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_quarter <= 2'd0;
      r_bit     <= 3'd0;
      r_rx      <= 8'h00;
      r_sample  <= 1'b0;
      r_ack_err <= 1'b0;
      r_rdata   <= 8'h00;
      r_done    <= 1'b0;
      r_scl_low <= 1'b0;
      r_sda_low <= 1'b0;
      r_addr    <= 7'h00;
      r_rw      <= 1'b0;
      r_wdata   <= 8'h00;
    end else begin
      r_state   <= w_state_nx;
      r_div     <= w_div_nx;
      r_quarter <= w_quarter_nx;
      r_bit     <= w_bit_nx;
      r_rx      <= w_rx_nx;
      r_sample  <= w_sample_nx;
      r_ack_err <= w_ack_err_nx;
      r_rdata   <= w_rdata_nx;
      r_done    <= w_done_nx;
      r_scl_low <= w_lines_nx[1];
      r_sda_low <= w_lines_nx[0];
      if (w_accept) begin
        r_addr  <= addr;
        r_rw    <= rw;
        r_wdata <= wdata;
      end
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign ack_err = r_ack_err;
  assign rdata   = r_rdata;
  assign scl_low = r_scl_low;
  assign sda_low = r_sda_low;

endmodule
